// File: rtl/e_mdu.sv
// e_mdu -- E-stage multiply/divide unit of the 5-stage MIPS core.
//
// Executes mult/multu/div/divu with a fixed busy time, owns the HI/LO
// registers and services mthi/mtlo/mfhi/mflo. The arithmetic result is
// computed at the start edge and parked in pending registers. It is
// committed to HI/LO when the busy counter expires.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   E_A        in   [31:0] rs operand (forwarded)
//   E_B        in   [31:0] rt operand (forwarded)
//   E_md_op    in   [3:0]  0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                          5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none
//   E_md_valid in   op belongs to a real instruction
//   E_start    out  combinational: arithmetic op accepted this cycle
//   E_busy     out  operation in flight (from the counter register)
//   E_HL_data  out  [31:0] HI for mfhi, LO for mflo, else 0
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic [3:0]  E_md_op,
  input  logic        E_md_valid,
  output logic        E_start,
  output logic        E_busy,
  output logic [31:0] E_HL_data
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  // 64-bit product. Operands are widened to 64 bits (sign- or zero-extended),
  // so the low 64 bits of the wide product are the exact result.
  function automatic logic [63:0] f_mul(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}. The quotient truncates toward zero and
  // the remainder takes the sign of the dividend. The caller discards the
  // result for a zero divisor. 0x80000000 / -1 is pinned explicitly,
  // because the signed 32-bit quotient overflows.
  function automatic logic [63:0] f_div(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    q  = 32'd0;
    r  = 32'd0;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_pend_wr;

  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;
  logic             w_res_wr;
  logic             w_arith;
  logic [CNT_W-1:0] w_load_cnt;

  assign E_busy  = (r_cnt != '0);
  assign w_arith = (E_md_op == OP_MULT) || (E_md_op == OP_MULTU) ||
                   (E_md_op == OP_DIV)  || (E_md_op == OP_DIVU);
  assign E_start = E_md_valid && w_arith && !E_busy;

  // The read mux ignores E_md_valid so that the output stays purely combinational.
  always_comb begin
    E_HL_data = 32'd0;
    if (E_md_op == OP_MFHI)      E_HL_data = r_hi;
    else if (E_md_op == OP_MFLO) E_HL_data = r_lo;
  end

  always_comb begin
    w_res_hi   = 32'd0;
    w_res_lo   = 32'd0;
    w_res_wr   = 1'b1;
    w_load_cnt = MULT_CNT;
    unique case (E_md_op)
      OP_MULT:  {w_res_hi, w_res_lo} = f_mul(E_A, E_B, 1'b1);
      OP_MULTU: {w_res_hi, w_res_lo} = f_mul(E_A, E_B, 1'b0);
      OP_DIV: begin
        {w_res_hi, w_res_lo} = f_div(E_A, E_B, 1'b1);
        w_res_wr   = (E_B != 32'd0);
        w_load_cnt = DIV_CNT;
      end
      OP_DIVU: begin
        {w_res_hi, w_res_lo} = f_div(E_A, E_B, 1'b0);
        w_res_wr   = (E_B != 32'd0);
        w_load_cnt = DIV_CNT;
      end
      default: ;
    endcase
  end

  // Busy takes precedence over everything except reset. Any op that slips
  // in while busy (restart or mt*) is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
    end else if (E_busy) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1) && r_pend_wr) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (E_start) begin
      r_cnt     <= w_load_cnt;
      r_pend_hi <= w_res_hi;
      r_pend_lo <= w_res_lo;
      r_pend_wr <= w_res_wr;
    end else if (E_md_valid && E_md_op == OP_MTHI) begin
      r_hi <= E_A;
    end else if (E_md_valid && E_md_op == OP_MTLO) begin
      r_lo <= E_A;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic [3:0]  E_md_op;
  logic        E_md_valid;
  logic        E_start;
  logic        E_busy;
  logic [31:0] E_HL_data;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .E_A(E_A), .E_B(E_B), .E_md_op(E_md_op),
    .E_md_valid(E_md_valid), .E_start(E_start), .E_busy(E_busy),
    .E_HL_data(E_HL_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    E_md_op    = 4'd0;
    E_md_valid = 1'b0;
    E_A        = 32'd0;
    E_B        = 32'd0;
  endtask

  // Combinational read-back of HI and LO against the model.
  task automatic check_hl(input string tag);
    E_md_valid = 1'b1;
    E_md_op    = 4'd7;
    #1;
    check({tag, " mfhi"}, E_HL_data, m_hi);
    E_md_op = 4'd8;
    #1;
    check({tag, " mflo"}, E_HL_data, m_lo);
    idle_in();
    #1;
  endtask

  // Reference arithmetic using 64-bit integers. wr=0 means HI/LO stay unchanged.
  function automatic void model_op(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] h,
                                   output logic [31:0] l, output bit wr);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint p;
    longint unsigned up;
    longint q;
    longint r;
    h = 32'd0; l = 32'd0; wr = 1'b1;
    case (op)
      4'd1: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      4'd2: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
      4'd3: if (b == 0) wr = 1'b0;
            else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      4'd4: if (b == 0) wr = 1'b0;
            else begin up = ua / ub; l = up[31:0]; up = ua % ub; h = up[31:0]; end
      default: wr = 1'b0;
    endcase
  endfunction

  // Counts busy cycles from the current (first busy) cycle, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (E_busy === 1'b1 && n < 200) begin
      n++;
      step();
    end
  endtask

  // Issue an arithmetic op from idle and check start, busy length and result.
  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] h;
    logic [31:0] l;
    bit          wr;
    int          n;
    model_op(op, a, b, h, l, wr);
    E_md_valid = 1'b1; E_md_op = op; E_A = a; E_B = b;
    #1;
    check({tag, " start"}, 32'(E_start), 32'd1);
    step();
    check({tag, " start drops"}, 32'(E_start), 32'd0);
    idle_in();
    #1;
    count_busy(n);
    check({tag, " busy cycles"}, n, (op <= 4'd2) ? MC : DC);
    if (wr) begin m_hi = h; m_lo = l; end
    check_hl(tag);
  endtask

  initial begin
    int          n;
    logic [31:0] old_lo;
    logic [3:0]  op;
    logic        vld;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] l;
    bit          wr;
    bit          exp_start;

    idle_in();
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;

    // 1: reset state, then reset clobbering a fresh mthi
    step(); step();
    reset = 1'b0;
    check("reset busy", 32'(E_busy), 32'd0);
    check_hl("reset");
    E_md_valid = 1'b1; E_md_op = 4'd5; E_A = 32'h1234_5678;
    step();
    idle_in();
    E_md_valid = 1'b1; E_md_op = 4'd7;
    #1;
    check("mthi written", E_HL_data, 32'h1234_5678);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("mthi cleared by reset", E_HL_data, 32'd0);
    idle_in();
    #1;

    // 2: mult / multu
    run_md("mult -1*2", 4'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    run_md("multu", 4'd2, 32'hFFFF_FFFF, 32'h0000_0002);

    // 3: div / divu / overflow
    run_md("div -7/2", 4'd3, 32'hFFFF_FFF9, 32'd2);
    run_md("divu 7/2", 4'd4, 32'd7, 32'd2);
    run_md("div ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);

    // 4: mthi/mtlo then divide by zero leaves them intact
    E_md_valid = 1'b1; E_md_op = 4'd5; E_A = 32'hAAAA_0000;
    step();
    E_md_op = 4'd6; E_A = 32'h0000_BBBB;
    step();
    idle_in();
    m_hi = 32'hAAAA_0000; m_lo = 32'h0000_BBBB;
    check_hl("mt");
    run_md("divu by 0", 4'd4, 32'd1234, 32'd0);

    // 5: ops injected while busy are ignored; reads return committed values
    old_lo = m_lo;
    E_md_valid = 1'b1; E_md_op = 4'd1; E_A = 32'd3; E_B = 32'd4;
    #1;
    check("inj start", 32'(E_start), 32'd1);
    step();
    n = 0;
    while (E_busy === 1'b1 && n < 200) begin
      idle_in();
      E_md_valid = 1'b1;
      case (n)
        0: begin E_md_op = 4'd1; E_A = 32'd5; E_B = 32'd5; end
        1: begin E_md_op = 4'd6; E_A = 32'h0000_DEAD; end
        2: E_md_op = 4'd8;
        default: E_md_valid = 1'b0;
      endcase
      #1;
      if (n == 0) check("inj mult no start", 32'(E_start), 32'd0);
      if (n == 2) check("inj mflo old", E_HL_data, old_lo);
      step();
      n++;
    end
    idle_in();
    check("inj busy cycles", n, MC);
    m_hi = 32'd0; m_lo = 32'd12;
    check_hl("inj result");
    E_md_valid = 1'b0; E_md_op = 4'd1; E_A = 32'd3; E_B = 32'd4;
    #1;
    check("invalid no start", 32'(E_start), 32'd0);
    step();
    check("invalid no busy", 32'(E_busy), 32'd0);
    idle_in();
    check_hl("invalid");

    // 6: reset mid-operation aborts the pending write
    E_md_valid = 1'b1; E_md_op = 4'd1; E_A = 32'd6; E_B = 32'd7;
    step();
    idle_in();
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort busy", 32'(E_busy), 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    check_hl("abort");
    repeat (10) step();
    check("abort still idle", 32'(E_busy), 32'd0);
    check_hl("abort late");

    // Random ops, always issued from idle
    for (int i = 0; i < 60; i++) begin
      op  = 4'($urandom_range(0, 15));
      vld = ($urandom_range(0, 7) != 0);
      a   = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      exp_start = vld && (op >= 4'd1) && (op <= 4'd4);
      E_md_valid = vld; E_md_op = op; E_A = a; E_B = b;
      #1;
      check("rnd start", 32'(E_start), 32'(exp_start));
      check("rnd hl", E_HL_data, (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0);
      step();
      idle_in();
      #1;
      if (exp_start) begin
        model_op(op, a, b, h, l, wr);
        count_busy(n);
        check("rnd busy cycles", n, (op <= 4'd2) ? MC : DC);
        if (wr) begin m_hi = h; m_lo = l; end
      end else begin
        if (vld && op == 4'd5) m_hi = a;
        if (vld && op == 4'd6) m_lo = a;
        check("rnd idle", 32'(E_busy), 32'd0);
      end
      check_hl("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
